// File: rtl/ocra1_grad_seq_if.sv
// Sample-in and DAC-word-out bus of the OCRA1 gradient sequencer.
// The sequencer is the slave. The sample source and the SPI core side are the master.
interface ocra1_grad_seq_if;
  logic [71:0] in_data_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [23:0] datax_o;
  logic [23:0] datay_o;
  logic [23:0] dataz_o;
  logic [23:0] dataz2_o;
  logic        valid_o;
  logic        busy_i;

  modport slave (
    input  in_data_i, in_valid_i, busy_i,
    output in_ready_o, datax_o, datay_o, dataz_o, dataz2_o, valid_o
  );

  modport master (
    output in_data_i, in_valid_i, busy_i,
    input  in_ready_o, datax_o, datay_o, dataz_o, dataz2_o, valid_o
  );
endinterface

// File: rtl/ocra1_grad_seq.sv
// Gradient sample sequencer: buffers 4-channel samples and formats them as DAC write words.
// Sends an init word once after reset, then issues one update per programmable interval.
module ocra1_grad_seq #(
  parameter int unsigned DEPTH     = 8,
  parameter logic [23:0] INIT_WORD = 24'h200002,
  parameter logic [3:0]  CMD       = 4'h1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic [15:0]              interval_i,
  input  logic                     clr_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     init_done_o,
  output logic                     underflow_o,
  output logic                     late_o,
  ocra1_grad_seq_if.slave          bus
);

  localparam int unsigned   AW   = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_WAIT} state_t;

  logic [71:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;

  state_t        r_state;
  logic [15:0]   r_timer;
  logic          r_pending;
  logic          r_guard;
  logic          r_valid;
  logic [23:0]   r_dx, r_dy, r_dz, r_dz2;
  logic          r_init_done;
  logic          r_underflow;
  logic          r_late;

  logic          w_ready;
  logic          w_push;
  logic          w_empty;
  logic          w_running;
  logic          w_tick;
  logic          w_issue;
  logic          w_late_evt;
  logic          w_under_evt;
  logic [71:0]   w_head;

  function automatic logic [23:0] fmt(input logic [17:0] v);
    return {CMD, v, 2'b00};
  endfunction

  assign w_ready     = (r_level < FULL);
  assign w_push      = bus.in_valid_i && w_ready;
  assign w_empty     = (r_level == '0);
  assign w_running   = (r_state != S_INIT) && en_i;
  // Greater-or-equal so a shrinking interval takes effect at once instead of wrapping the timer.
  assign w_tick      = w_running && (r_timer >= interval_i);
  assign w_issue     = en_i && (r_state == S_RUN) && r_pending && !bus.busy_i && !w_empty;
  assign w_late_evt  = w_tick && r_pending;
  assign w_under_evt = w_tick && !r_pending && w_empty;
  assign w_head      = r_mem[r_rd_ptr];

  // NOTE: sequential state always uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_issue)      r_level <= r_level + 1'b1;
      else if (!w_push && w_issue) r_level <= r_level - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only read while level says it was written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.in_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_INIT;
      r_timer     <= '0;
      r_pending   <= 1'b0;
      r_guard     <= 1'b0;
      r_valid     <= 1'b0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_dz        <= '0;
      r_dz2       <= '0;
      r_init_done <= 1'b0;
      r_underflow <= 1'b0;
      r_late      <= 1'b0;
    end else begin
      r_valid <= 1'b0;

      if (!w_running || w_tick) r_timer <= '0;
      else                      r_timer <= r_timer + 16'd1;

      if (!w_running || w_issue)  r_pending <= 1'b0;
      else if (w_tick && !w_empty) r_pending <= 1'b1;

      if (w_under_evt) r_underflow <= 1'b1;
      else if (clr_i)  r_underflow <= 1'b0;
      if (w_late_evt)  r_late <= 1'b1;
      else if (clr_i)  r_late <= 1'b0;

      case (r_state)
        S_INIT: begin
          if (!bus.busy_i) begin
            r_dx        <= INIT_WORD;
            r_dy        <= INIT_WORD;
            r_dz        <= INIT_WORD;
            r_dz2       <= INIT_WORD;
            r_valid     <= 1'b1;
            r_init_done <= 1'b1;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_issue) begin
            r_dx    <= fmt(w_head[17:0]);
            r_dy    <= fmt(w_head[35:18]);
            r_dz    <= fmt(w_head[53:36]);
            r_dz2   <= fmt(w_head[71:54]);
            r_valid <= 1'b1;
            r_guard <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // The core either acknowledges by raising busy or the two-cycle guard expires.
          if (bus.busy_i || r_guard) r_state <= S_RUN;
          else                       r_guard <= 1'b1;
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign bus.in_ready_o = w_ready;
  assign bus.datax_o    = r_dx;
  assign bus.datay_o    = r_dy;
  assign bus.dataz_o    = r_dz;
  assign bus.dataz2_o   = r_dz2;
  assign bus.valid_o    = r_valid;
  assign level_o        = r_level;
  assign init_done_o    = r_init_done;
  assign underflow_o    = r_underflow;
  assign late_o         = r_late;

endmodule

// File: doc/ocra1_grad_seq.md
Name: ocra1_grad_seq

Overview:
- Upstream feeder for the OCRA1 SPI interface core.
- Buffers 4-channel 18-bit gradient samples in a small FIFO and formats each as a 24-bit DAC write word.
- Issues one update per programmable interval, honouring the core's busy line.
- After reset, sends the DAC initialisation word to all channels once before any sample.

Parameters:
- DEPTH, 8, FIFO depth in sample-sets; power of two, ≥2.
- INIT_WORD, 24'h200002, word sent on all four channels after reset.
- CMD, 4'h1, DAC write command nibble.

Ports:
- clk  in  1  system clock (125 MHz)
- rst  in  1  synchronous reset, active-high
- en_i  in  1  run enable for interval timer and sample issue
- interval_i  in  16  update period minus one, in clk cycles
- clr_i  in  1  clears sticky status flags
- in_data_i  in  72  sample set {z2[71:54], z[53:36], y[35:18], x[17:0]}
- in_valid_i  in  1  sample set valid
- in_ready_o  out  1  FIFO can accept a sample set
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy
- datax_o, datay_o, dataz_o, dataz2_o  out  24 each  words to interface core
- valid_o  out  1  one-cycle strobe, data_o valid
- busy_i  in  1  interface core busy
- init_done_o  out  1  init word has been issued
- underflow_o  out  1  sticky: tick with FIFO empty
- late_o  out  1  sticky: tick while previous update still pending

Behaviour:
- Synchronous active-high reset; all outputs are registered except in_ready_o.
- Reset values:
  - data outputs 0, valid_o 0, init_done_o 0, underflow_o 0, late_o 0, level_o 0.
  - FIFO flushed, timer 0, pending 0, FSM in S_INIT.
  - Reset mid-transfer aborts everything; init is resent afterwards.
- FIFO:
  - in_ready_o = (level_o < DEPTH), combinational.
  - Push when in_valid_i && in_ready_o.
  - A push and pop in the same cycle leave level unchanged.
  - When full, in_ready_o is 0 even if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH; first-in first-out order.
- Formatting: each channel word = {CMD, v[17:0], 2'b00}, e.g. v=1 → 24'h100004, v=18'h3FFFF → 24'h1FFFFC.
- FSM S_INIT:
  - First cycle with busy_i=0: drive all four data outputs = INIT_WORD, valid_o=1 for one cycle.
  - Set init_done_o=1 and go to S_RUN.
  - en_i is ignored in S_INIT; FIFO accepts pushes.
- FSM S_RUN, timer:
  - While en_i=0, the timer is held at 0 and no tick or pending is generated.
  - When en_i=1, the timer counts up to interval_i, then wraps to 0 and asserts tick for that cycle.
  - Period = interval_i+1 cycles; interval_i=0 gives a tick every cycle.
  - interval_i is sampled on every compare, so changes apply immediately.
  - First tick comes interval_i+1 cycles after en_i rises.
- FSM S_RUN, tick handling:
  - Tick with level=0: underflow_o set, nothing issued, DAC keeps its previous value.
  - Tick with level>0 and pending=0: pending set.
  - Tick with pending=1: late_o set; ticks never accumulate (at most one pending).
- FSM S_RUN, issue:
  - Issue condition: pending && busy_i==0 && level>0.
  - On issue, pop one entry; the next cycle has formatted data and valid_o=1, and pending clears.
  - Pop-to-valid latency is 1 cycle; valid_o is never asserted on consecutive cycles.
  - After issuing, no further issue until busy_i has been sampled high then low, or 2 cycles have elapsed.
  - Simplest compliant form: after issue, wait for busy_i=1 or a 2-cycle guard, then resume checking.
  - Data outputs hold their last value when valid_o=0.
- If en_i drops while pending=1: pending is cleared and nothing is issued.
- Status flags:
  - clr_i clears underflow_o and late_o on the next edge.
  - If clr_i coincides with a set event, the set wins.

Test Plan:
- Reset, busy_i=0 → single valid_o on cycle 1 after rst drops, all four data = 24'h200002, init_done_o=1.
- Push (1,2,3,4) and (5,6,7,8); interval_i=99; en_i=1; busy_i model 30 cycles per transfer → valid_o at cycle ~100 with 24'h100004/100008/10000C/100010, at ~200 with 24'h100014/…/100020; underflow_o=1 at ~300.
- Push -1 on all channels (18'h3FFFF) → all data = 24'h1FFFFC.
- Fill DEPTH=8 sets with en_i=0 → in_ready_o=0, level_o=8, 9th push refused; enable → order preserved, level decrements per update.
- interval_i=9, busy_i held high 25 cycles → late_o=1, exactly one issue after busy_i falls; clr_i → late_o=0.
- Assert rst mid-run with level_o=5 → level_o=0, init resent, no stale samples emitted.
